// File: rtl/bip_pkg.sv
//------------------------------------------------------------------------------
// bip_pkg : shared opcodes, sequencer states and default widths for BIP.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bip_pkg;

    localparam int PC_W     = 11;
    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_HALT = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_STO  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_SUBI = 5'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD    = 3'd2,
        DECODE  = 3'd3,
        MEMWAIT = 3'd4,
        EXEC    = 3'd5,
        HALTED  = 3'd6
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s == FETCH) || (s == LOAD) || (s == DECODE) ||
               (s == MEMWAIT) || (s == EXEC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bip_sat_counter.sv
//------------------------------------------------------------------------------
// bip_sat_counter : clear-on-start cycle counter that sticks at all ones.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bip_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/bip_sequencer.sv
//------------------------------------------------------------------------------
// bip_sequencer : fetch/load/decode/wait/execute control for the BIP CPU.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bip_sequencer #(
    parameter int PC_W     = bip_pkg::PC_W,
    parameter int INSTR_W  = bip_pkg::INSTR_W,
    parameter int OPCODE_W = bip_pkg::OPCODE_W,
    parameter int CNT_W    = 32,
    parameter int RAM_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [PC_W-1:0]     pm_addr,
    output logic                pm_rd,
    input  logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [PC_W-1:0]     operand,
    input  logic                dec_wr_pc,
    input  logic                dec_wr_acc,
    input  logic                dec_wr_ram,
    input  logic                dec_rd_ram,
    output logic                wr_pc_o,
    output logic                wr_acc_o,
    output logic                wr_ram_o,
    output logic                rd_ram_o,
    output logic                busy,
    output logic                halted,
    output logic [CNT_W-1:0]    cycle_count
);

    import bip_pkg::*;

    localparam int WAIT_W = 3;

    state_t              r_state;
    state_t              w_next;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_wr_pc;
    logic                r_wr_acc;
    logic                r_wr_ram;
    logic                r_rd_ram;

    logic [OPCODE_W-1:0] w_opcode;
    logic                w_defined;
    logic                w_is_halt;
    logic                w_start_ok;
    logic                w_busy;
    logic                w_exec_next;
    logic                w_wr_pc_d;
    logic                w_wr_acc_d;
    logic                w_wr_ram_d;
    logic                w_rd_ram_d;

    assign w_opcode   = r_ir[INSTR_W-1 -: OPCODE_W];
    assign w_defined  = (w_opcode <= OPCODE_W'(OP_SUBI));
    assign w_is_halt  = (w_opcode == OPCODE_W'(OP_HALT));
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == HALTED));
    assign w_busy     = state_is_busy(r_state);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   w_next = LOAD;
            LOAD:    w_next = DECODE;
            DECODE: begin
                if (w_is_halt)
                    w_next = HALTED;
                else if (w_defined && dec_rd_ram && (RAM_WAIT != 0))
                    w_next = MEMWAIT;
                else
                    w_next = EXEC;
            end
            MEMWAIT: if (r_wait <= WAIT_W'(1)) w_next = EXEC;
            EXEC:    w_next = FETCH;
            HALTED:  if (start) w_next = FETCH;
            default: w_next = IDLE;
        endcase
    end

    // Strobes are registered on entry to EXEC/MEMWAIT so they track the state
    // exactly; undefined opcodes ignore the decoder and just advance the pc.
    always_comb begin
        w_exec_next = (w_next == EXEC);
        w_wr_pc_d   = w_exec_next && (!w_defined || dec_wr_pc);
        w_wr_acc_d  = w_exec_next && w_defined && dec_wr_acc;
        w_wr_ram_d  = w_exec_next && w_defined && dec_wr_ram;
        w_rd_ram_d  = (w_next == MEMWAIT) ||
                      (w_exec_next && w_defined && dec_rd_ram);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_wait   <= '0;
            r_wr_pc  <= 1'b0;
            r_wr_acc <= 1'b0;
            r_wr_ram <= 1'b0;
            r_rd_ram <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wr_pc  <= w_wr_pc_d;
            r_wr_acc <= w_wr_acc_d;
            r_wr_ram <= w_wr_ram_d;
            r_rd_ram <= w_rd_ram_d;

            if (w_start_ok)
                r_pc <= '0;
            else if ((r_state == EXEC) && r_wr_pc)
                r_pc <= r_pc + PC_W'(1);

            if (r_state == LOAD)
                r_ir <= instr;

            if (r_state == DECODE)
                r_wait <= WAIT_W'(RAM_WAIT);
            else if ((r_state == MEMWAIT) && (r_wait != '0))
                r_wait <= r_wait - WAIT_W'(1);
        end
    end

    bip_sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_ok),
        .inc   (w_busy),
        .count (cycle_count)
    );

    assign pm_addr  = r_pc;
    assign pm_rd    = (r_state == FETCH);
    assign opcode   = w_opcode;
    assign operand  = r_ir[PC_W-1:0];
    assign wr_pc_o  = r_wr_pc;
    assign wr_acc_o = r_wr_acc;
    assign wr_ram_o = r_wr_ram;
    assign rd_ram_o = r_rd_ram;
    assign busy     = w_busy;
    assign halted   = (r_state == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_bip_sequencer.sv
//------------------------------------------------------------------------------
// tb_bip_sequencer : directed scoreboard bench for bip_sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bip_sequencer;

    localparam int RW_A   = 2;
    localparam int PCW_B  = 2;
    localparam int CNTW_B = 4;

    typedef struct packed {
        logic [10:0] pc;
        logic [10:0] opnd;
        logic [3:0]  strb;   // {wr_pc, wr_acc, wr_ram, rd_ram}
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    int acc_at[$];
    int busy_n;

    // DUT A: default widths, two RAM wait cycles
    logic [10:0] pm_addr_a, operand_a;
    logic        pm_rd_a, dwpc_a, dwacc_a, dwram_a, drram_a;
    logic [15:0] instr_a;
    logic [4:0]  opcode_a;
    logic        wr_pc_a, wr_acc_a, wr_ram_a, rd_ram_a, busy_a, halted_a;
    logic [31:0] cnt_a;
    logic [15:0] mem_a [0:2047];

    // DUT B: 2-bit pc, 4-bit counter
    logic [PCW_B-1:0]  pm_addr_b, operand_b;
    logic              pm_rd_b, dwpc_b, dwacc_b, dwram_b, drram_b;
    logic [15:0]       instr_b;
    logic [4:0]        opcode_b;
    logic              wr_pc_b, wr_acc_b, wr_ram_b, rd_ram_b, busy_b, halted_b;
    logic [CNTW_B-1:0] cnt_b;
    logic [15:0]       mem_b [0:3];

    bip_sequencer #(.RAM_WAIT(RW_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .pm_addr(pm_addr_a), .pm_rd(pm_rd_a), .instr(instr_a),
        .opcode(opcode_a), .operand(operand_a),
        .dec_wr_pc(dwpc_a), .dec_wr_acc(dwacc_a), .dec_wr_ram(dwram_a), .dec_rd_ram(drram_a),
        .wr_pc_o(wr_pc_a), .wr_acc_o(wr_acc_a), .wr_ram_o(wr_ram_a), .rd_ram_o(rd_ram_a),
        .busy(busy_a), .halted(halted_a), .cycle_count(cnt_a)
    );

    bip_sequencer #(.PC_W(PCW_B), .CNT_W(CNTW_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .pm_addr(pm_addr_b), .pm_rd(pm_rd_b), .instr(instr_b),
        .opcode(opcode_b), .operand(operand_b),
        .dec_wr_pc(dwpc_b), .dec_wr_acc(dwacc_b), .dec_wr_ram(dwram_b), .dec_rd_ram(drram_b),
        .wr_pc_o(wr_pc_b), .wr_acc_o(wr_acc_b), .wr_ram_o(wr_ram_b), .rd_ram_o(rd_ram_b),
        .busy(busy_b), .halted(halted_b), .cycle_count(cnt_b)
    );

    // Decoder model; undefined opcodes assert every level to prove they are ignored.
    function automatic logic [3:0] dec_lv(input logic [4:0] op);
        case (op)
            5'd0:                     return 4'b0000;
            5'd1:                     return 4'b1010;
            5'd2, 5'd4, 5'd6:         return 4'b1101;
            5'd3, 5'd5, 5'd7:         return 4'b1100;
            default:                  return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input logic [4:0] op);
        return (op > 5'd7) ? 4'b1000 : dec_lv(op);
    endfunction

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] arg);
        return {op, arg};
    endfunction

    always_comb {dwpc_a, dwacc_a, dwram_a, drram_a} = dec_lv(opcode_a);
    always_comb {dwpc_b, dwacc_b, dwram_b, drram_b} = dec_lv(opcode_b);

    always @(posedge clk) if (pm_rd_a) instr_a <= mem_a[pm_addr_a];
    always @(posedge clk) if (pm_rd_b) instr_b <= mem_b[pm_addr_b];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [10:0] pc, input logic [15:0] word);
        exp_t e;
        e.pc   = pc;
        e.opnd = word[10:0];
        e.strb = exp_strb(word[15:11]);
        sb.push_back(e);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Observes DUT A from the first FETCH cycle until HALTED; poke0/poke1 raise
    // start during the given cycle numbers.
    task automatic run_a(input int poke0, input int poke1);
        exp_t e;
        int k;
        int rd_run;
        k = 1;
        rd_run = 0;
        acc_at.delete();
        chk("first_pm_rd", 32'(pm_rd_a), 32'd1);
        chk("first_pc", 32'(pm_addr_a), 32'd0);
        chk("first_cnt", cnt_a, 32'd0);
        while (!halted_a && k < 200) begin
            if (wr_acc_a) acc_at.push_back(k);
            if (rd_ram_a) begin
                rd_run++;
                if (sb.size() > 0) chk("rd_operand", 32'(operand_a), 32'(sb[0].opnd));
            end
            if (wr_pc_a) begin
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL sb_underflow: observed=exec_at_pc_%0h expected=no_exec", pm_addr_a);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("exec_pc", 32'(pm_addr_a), 32'(e.pc));
                    chk("exec_operand", 32'(operand_a), 32'(e.opnd));
                    chk("exec_strobes", 32'({wr_pc_a, wr_acc_a, wr_ram_a, rd_ram_a}), 32'(e.strb));
                    chk("rd_len", rd_run, e.strb[0] ? (RW_A + 1) : 0);
                end
                rd_run = 0;
            end else begin
                chk("no_stray", 32'({wr_acc_a, wr_ram_a}), 32'd0);
            end
            start_a = (k == poke0) || (k == poke1);
            @(negedge clk);
            k++;
        end
        start_a = 1'b0;
        chk("halt_reached", 32'(halted_a), 32'd1);
        chk("sb_drained", sb.size(), 0);
        busy_n = k - 1;
    endtask

    task automatic load_prog2();
        mem_a[0] = ins(5'd3, 11'd5);
        mem_a[1] = ins(5'd5, 11'd3);
        mem_a[2] = ins(5'd0, 11'd0);
        push(11'd0, mem_a[0]);
        push(11'd1, mem_a[1]);
    endtask

    task automatic check_prog2(input string tag);
        chk({tag, "_acc_n"}, acc_at.size(), 2);
        chk({tag, "_acc0"}, (acc_at.size() > 0) ? acc_at[0] : -1, 4);
        chk({tag, "_acc1"}, (acc_at.size() > 1) ? acc_at[1] : -1, 8);
        chk({tag, "_busy"}, busy_n, 11);
        chk({tag, "_cnt"}, cnt_a, 32'd11);
        chk({tag, "_pc"}, 32'(pm_addr_a), 32'd2);
    endtask

    initial begin
        int k;
        int pcs[$];

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        chk("rst_halted", 32'({halted_a, halted_b}), 32'd0);
        chk("rst_pm", 32'({pm_rd_a, pm_addr_a}), 32'd0);
        chk("rst_cnt", cnt_a, 32'd0);
        chk("rst_strb", 32'({wr_pc_a, wr_acc_a, wr_ram_a, rd_ram_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in MEMWAIT
        mem_a[0] = ins(5'd2, 11'h010);
        mem_a[1] = ins(5'd0, 11'd0);
        pulse_start_a();
        repeat (3) @(negedge clk);
        chk("mw_rd_ram", 32'({busy_a, rd_ram_a}), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({wr_pc_a, wr_acc_a, wr_ram_a, rd_ram_a, busy_a, halted_a, pm_rd_a}), 32'd0);
        chk("mid_rst_cnt", cnt_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'({busy_a, halted_a}), 32'd0);
        chk("post_rst_pc", 32'(pm_addr_a), 32'd0);
        chk("post_rst_cnt", cnt_a, 32'd0);

        // RAM read with two wait cycles
        push(11'd0, mem_a[0]);
        pulse_start_a();
        run_a(0, 0);
        chk("ld_busy", busy_n, 9);
        chk("ld_cnt", cnt_a, 32'd9);
        chk("ld_acc_at", (acc_at.size() == 1) ? acc_at[0] : -1, 6);

        // LDI 5; ADDI 3; HALT, restarted from HALTED
        load_prog2();
        pulse_start_a();
        run_a(0, 0);
        check_prog2("prog");

        // Undefined opcode executes as NOP
        mem_a[0] = ins(5'd12, 11'h7FF);
        mem_a[1] = ins(5'd3, 11'd1);
        mem_a[2] = ins(5'd0, 11'd0);
        push(11'd0, mem_a[0]);
        push(11'd1, mem_a[1]);
        pulse_start_a();
        run_a(0, 0);
        chk("undef_busy", busy_n, 11);
        chk("undef_pc", 32'(pm_addr_a), 32'd2);
        chk("undef_acc_at", (acc_at.size() == 1) ? acc_at[0] : -1, 8);

        // start during FETCH (cycle 5) and EXEC (cycle 8) is ignored
        load_prog2();
        pulse_start_a();
        run_a(5, 8);
        check_prog2("busy_start");

        // PC wrap on a 2-bit pc; HALT appears at address 0 on the second pass
        for (int i = 0; i < 4; i++) mem_b[i] = ins(5'd31, 11'(i));
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 1;
        while (!halted_b && k < 100) begin
            if (wr_pc_b) begin
                pcs.push_back(int'(pm_addr_b));
                chk("nop_strb_b", 32'({wr_acc_b, wr_ram_b, rd_ram_b}), 32'd0);
                chk("nop_operand_b", 32'(operand_b), 32'(pm_addr_b));
                mem_b[0] = ins(5'd0, 11'd0);
            end
            @(negedge clk);
            k++;
        end
        chk("wrap_halted", 32'(halted_b), 32'd1);
        chk("wrap_n", pcs.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("wrap_pc_seq", (pcs.size() > i) ? pcs[i] : -1, i);
        chk("wrap_pc_final", 32'(pm_addr_b), 32'd0);
        chk("wrap_busy", k - 1, 19);
        chk("wrap_cnt_sat", 32'(cnt_b), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/bip_sequencer.md
Name: bip_sequencer

Overview:
- Multi-cycle control sequencer for the BIP accumulator CPU.
- Steps each instruction through fetch, load, decode, optional RAM wait and execute.
- Drives program-memory reads and exposes the latched opcode to the instruction decoder.
- Gates the decoder's WrPC/WrAcc/WrRam/RdRam levels into single, correctly timed strobes for the PC, accumulator and data RAM. Provides halt status and a cycle counter for the debug unit.

Parameters:
- PC_W, 11, program counter and operand width.
- INSTR_W, 16, instruction width (opcode in bits [15:11], operand in bits [10:0]).
- OPCODE_W, 5, opcode width.
- CNT_W, 32, cycle counter width.
- RAM_WAIT, 1, extra cycles of data-RAM read latency (range 0..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, level sampled. Accepted only in IDLE or HALTED.
- pm_addr  out  PC_W  program memory address (equals pc).
- pm_rd  out  1  program memory read enable. Memory is synchronous with 1-cycle latency.
- instr  in  INSTR_W  program memory read data.
- opcode  out  OPCODE_W  IR[15:11], to the instruction decoder.
- operand  out  PC_W  IR[10:0], to the datapath (immediate or RAM address).
- dec_wr_pc, dec_wr_acc, dec_wr_ram, dec_rd_ram  in  1 each  decoder control levels for the current opcode.
- wr_pc_o, wr_acc_o, wr_ram_o, rd_ram_o  out  1 each  gated strobes to the datapath.
- busy  out  1  high in FETCH, LOAD, DECODE, MEMWAIT and EXEC.
- halted  out  1  high in HALTED.
- cycle_count  out  CNT_W  number of busy cycles since the last accepted start.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, pc=0, IR=0, wait counter=0, cycle_count=0. All outputs are 0, and they go to 0 immediately on assertion, not at the next clock edge.
- All outputs are registered or decoded from state. There are no combinational paths from start to any output.
- States and transitions:
  - IDLE: start=1 -> FETCH; pc<=0, cycle_count<=0.
  - FETCH: pm_rd=1, pm_addr=pc -> LOAD.
  - LOAD: IR<=instr -> DECODE.
  - DECODE: if opcode==OP_HALT -> HALTED. Else if the opcode is defined (0..7) and dec_rd_ram=1 -> MEMWAIT with wait counter loaded with RAM_WAIT. Otherwise -> EXEC. When RAM_WAIT=0, a RAM read goes directly to EXEC.
  - MEMWAIT: rd_ram_o=1; counter decrements; when it reaches 1 -> EXEC.
  - EXEC: strobes equal the decoder levels for exactly one cycle. rd_ram_o stays high from MEMWAIT through EXEC. If wr_pc_o=1, pc<=pc+1, wrapping from 2^PC_W-1 to 0. Then -> FETCH.
  - HALTED: halted=1; pc and IR are held. start=1 -> FETCH with pc<=0 and cycle_count<=0.
- Undefined opcodes (8..31) are executed as NOP:
  - decoder inputs are ignored;
  - wr_acc_o, wr_ram_o and rd_ram_o stay 0;
  - wr_pc_o is forced to 1, so pc advances.
- Strobes are 0 in every state other than EXEC, except rd_ram_o during MEMWAIT.
- Latency: non-memory instruction = 4 cycles; RAM-read instruction = 4+RAM_WAIT cycles; HALT = 3 cycles from FETCH to HALTED.
- cycle_count increments in every busy state and saturates at all ones (no wrap).
- start while busy is ignored.
- start held high is harmless after HALTED: it restarts at the next cycle, since start is a level.

Decomposition:
- Package bip_pkg holds:
  - opcode constants OP_HALT=0, OP_STO=1, OP_LD=2, OP_LDI=3, OP_ADD=4, OP_ADDI=5, OP_SUB=6, OP_SUBI=7;
  - the state enum {IDLE, FETCH, LOAD, DECODE, MEMWAIT, EXEC, HALTED};
  - default widths PC_W, INSTR_W, OPCODE_W.
- One sub-module, bip_sat_counter, implements the saturating clear-on-start cycle counter. All other logic stays in bip_sequencer.

Test Plan:
1. Reset assertion mid-run (in MEMWAIT) -> all strobes, busy, halted and pm_rd drop to 0 immediately. After release, the block is in IDLE with pc=0 and cycle_count=0.
2. Program LDI 5; ADDI 3; HALT, with the decoder model connected, then a start pulse:
   - wr_acc_o pulses in cycles 4 and 8 after start is accepted;
   - pc goes 0->1->2;
   - halted rises after 11 busy cycles, with cycle_count=11.
3. RAM_WAIT=2, instruction LD 0x010 -> rd_ram_o is high for 3 consecutive cycles (MEMWAIT x2 plus EXEC), wr_acc_o is high only in the last of them, and operand=0x010 throughout.
4. Opcode 12 (undefined) -> wr_acc_o, wr_ram_o and rd_ram_o stay 0; wr_pc_o pulses once; pc increments; the sequencer fetches the next instruction.
5. PC_W=2 with a program of four NOPs (opcode 31) followed by HALT at address 0 on the wrap -> pc sequence is 0,1,2,3,0, then HALTED.
6. start pulses during FETCH and EXEC of a running program -> no effect on pc, cycle_count or state. A start in HALTED restarts execution from pc=0.
